// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO word serializer.
package fifo_ser_pkg;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} ser_state_t;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned FRAME_BITS = DATA_W_DEF + 2;
  localparam logic        TX_IDLE    = 1'b1;

  // Wire cycles of one start+data+stop frame
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_baud.sv
// Bit-period timer: pulses bit_done every CLKS_PER_BIT cycles while not cleared.
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_clear,
  output logic o_bit_done_c
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit_done_c = !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a FIFO and sends each as a start/data/stop framed serial bit stream.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned LSB_FIRST    = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              tx_out,
  output logic              tx_busy,
  output logic [CNT_W-1:0]  words_sent
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_W - 1);

  ser_state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0]     r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  r_rd_en;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_words;
  logic                  w_ws_inc;
  logic                  w_go;
  logic                  w_clear;
  logic                  w_bit_done;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk          (clk),
    .rstN         (rstN),
    .i_clear      (w_clear),
    .o_bit_done_c (w_bit_done)
  );

  // Bit timer only runs while a frame is on the wire
  assign w_clear = (r_state == IDLE) || (r_state == POP) || (r_state == LOAD);
  assign w_go    = enable && !fifo_empty;

  // Next-state, datapath and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_ws_inc      = 1'b0;
    w_tx_nxt      = TX_IDLE;

    case (r_state)
      IDLE:  if (w_go) w_state_nxt = POP;
      POP:   w_state_nxt = LOAD;
      LOAD: begin
        w_shift_nxt = fifo_rd_data;
        w_state_nxt = START;
      end
      START: begin
        if (w_bit_done) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = DATA;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            w_shift_nxt   = (LSB_FIRST != 0) ? {1'b0, r_shift[DATA_W-1:1]}
                                             : {r_shift[DATA_W-2:0], 1'b0};
          end
        end
      end
      STOP: begin
        if (w_bit_done) begin
          w_ws_inc    = 1'b1;
          w_state_nxt = w_go ? POP : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level is registered from the state we are entering
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = (LSB_FIRST != 0) ? w_shift_nxt[0] : w_shift_nxt[DATA_W-1];
      default: w_tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= TX_IDLE;
      r_rd_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_words   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_tx      <= w_tx_nxt;
      r_rd_en   <= (w_state_nxt == POP);
      r_busy    <= (w_state_nxt != IDLE);
      r_words   <= r_words + CNT_W'(w_ws_inc);
    end
  end

  assign tx_out     = r_tx;
  assign fifo_rd_en = r_rd_en;
  assign tx_busy    = r_busy;
  assign words_sent = r_words;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench: two serializers (LSB-first and MSB-first) fed by FIFO models and decoded by serial receivers.
module tb_fifo_word_serializer;
  import fifo_ser_pkg::*;

  localparam int unsigned CPB    = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned FRAME  = FRAME_BITS * CPB;
  localparam int unsigned PERIOD = FRAME + 2;

  logic        clk  = 1'b0;
  logic        rstN = 1'b1;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        empty0 = 1'b1, empty1 = 1'b1;
  logic [15:0] rdd0 = '0, rdd1 = '0;
  logic        rd0, rd1, tx0, tx1, busy0, busy1;
  logic [7:0]  ws0, ws1;

  always #5 clk = ~clk;

  fifo_word_serializer #(.DATA_W(16), .CLKS_PER_BIT(CPB), .LSB_FIRST(1), .CNT_W(8)) dut0 (
    .clk(clk), .rstN(rstN), .enable(en0), .fifo_empty(empty0), .fifo_rd_en(rd0),
    .fifo_rd_data(rdd0), .tx_out(tx0), .tx_busy(busy0), .words_sent(ws0));

  fifo_word_serializer #(.DATA_W(16), .CLKS_PER_BIT(CPB), .LSB_FIRST(0), .CNT_W(8)) dut1 (
    .clk(clk), .rstN(rstN), .enable(en1), .fifo_empty(empty1), .fifo_rd_en(rd1),
    .fifo_rd_data(rdd1), .tx_out(tx1), .tx_busy(busy1), .words_sent(ws1));

  int checks = 0, failures = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 8-deep FIFO models; read data appears on the edge after the pop
  logic [15:0] q0[$], q1[$];
  logic        p0_v = 1'b0, p1_v = 1'b0;
  logic [15:0] p0_d = '0, p1_d = '0;

  always @(posedge clk) begin
    if (rd0 === 1'b1 && q0.size() != 0) rdd0 <= q0.pop_front();
    if (p0_v && q0.size() < 8) q0.push_back(p0_d);
    empty0 <= (q0.size() == 0);
  end

  always @(posedge clk) begin
    if (rd1 === 1'b1 && q1.size() != 0) rdd1 <= q1.pop_front();
    if (p1_v && q1.size() < 8) q1.push_back(p1_d);
    empty1 <= (q1.size() == 0);
  end

  // Pop strobe and busy-window monitors
  wire [1:0] w_rd   = {rd1, rd0};
  wire [1:0] w_emp  = {empty1, empty0};
  wire [1:0] w_busy = {busy1, busy0};
  wire [1:0] w_tx   = {tx1, tx0};
  int          rd_cnt[2], bad_rd[2], busy_run[2], busy_len[2];
  int unsigned rd_cyc[2];

  initial for (int i = 0; i < 2; i++) begin
    rd_cnt[i] = 0; bad_rd[i] = 0; busy_run[i] = 0; busy_len[i] = 0; rd_cyc[i] = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_rd[i] === 1'b1) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        rd_cyc[i] <= cyc;
        if (w_emp[i]) bad_rd[i] <= bad_rd[i] + 1;
      end
      if (w_busy[i] === 1'b1) busy_run[i] <= busy_run[i] + 1;
      else if (busy_run[i] != 0) begin
        busy_len[i] <= busy_run[i];
        busy_run[i] <= 0;
      end
    end
  end

  function automatic logic [15:0] rev16(input logic [15:0] x);
    logic [15:0] r;
    for (int b = 0; b < 16; b++) r[b] = x[15-b];
    return r;
  endfunction

  // Serial receivers: detect start edge, sample mid-bit, rebuild word per bit order
  logic        rx_busy[2], rx_prev[2], rx_ok[2];
  int unsigned rx_cnt[2], rx_start[2];
  int          rx_fe[2];
  logic [15:0] rx_raw[2];
  logic [15:0] rx_q0[$], rx_q1[$];
  int unsigned rx_t0[$], rx_t1[$];

  initial for (int i = 0; i < 2; i++) begin
    rx_busy[i] = 1'b0; rx_prev[i] = 1'b1; rx_ok[i] = 1'b0;
    rx_cnt[i] = 0; rx_start[i] = 0; rx_fe[i] = 0; rx_raw[i] = '0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rstN) begin
        rx_busy[i] <= 1'b0;
        rx_prev[i] <= 1'b1;
      end else begin
        rx_prev[i] <= w_tx[i];
        if (!rx_busy[i]) begin
          if (rx_prev[i] && w_tx[i] === 1'b0) begin
            rx_busy[i]  <= 1'b1;
            rx_cnt[i]   <= 1;
            rx_start[i] <= cyc;
          end
        end else begin
          rx_cnt[i] <= rx_cnt[i] + 1;
          if (rx_cnt[i] % CPB == CPB / 2) begin
            if (rx_cnt[i] / CPB == 0) rx_ok[i] <= (w_tx[i] === 1'b0);
            else if (rx_cnt[i] / CPB <= DW) rx_raw[i][rx_cnt[i] / CPB - 1] <= w_tx[i];
            else begin
              rx_busy[i] <= 1'b0;
              if (!(rx_ok[i] && w_tx[i] === 1'b1)) rx_fe[i] <= rx_fe[i] + 1;
              if (i == 0) begin rx_q0.push_back(rx_raw[0]); rx_t0.push_back(rx_start[0]); end
              else begin rx_q1.push_back(rev16(rx_raw[1])); rx_t1.push_back(rx_start[1]); end
            end
          end
        end
      end
    end
  end

  int exp_ws = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [15:0] w);
    @(negedge clk); p0_d = w; p0_v = 1'b1;
    @(negedge clk); p0_v = 1'b0;
  endtask

  task automatic push1(input logic [15:0] w);
    int g;
    @(negedge clk);
    g = 0;
    while (q1.size() >= 8 && g < 2000) begin @(negedge clk); g++; end
    p1_d = w; p1_v = 1'b1;
    @(negedge clk); p1_v = 1'b0;
  endtask

  task automatic wait_rx(input int ch, input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (((ch == 0) ? rx_q0.size() : rx_q1.size()) >= target) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++; if (tx0 !== 1'b1)   begin failures++; $display("FAIL reset_tx0 got=%b exp=1", tx0); end
    checks++; if (rd0 !== 1'b0)   begin failures++; $display("FAIL reset_rd0 got=%b exp=0", rd0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL reset_busy0 got=%b exp=0", busy0); end
    checks++; if (ws0 !== 8'd0)   begin failures++; $display("FAIL reset_ws0 got=%0d exp=0", ws0); end
    checks++; if (tx1 !== 1'b1)   begin failures++; $display("FAIL reset_tx1 got=%b exp=1", tx1); end
    rstN = 1'b1;
  endtask

  task automatic test_idle_empty;
    int bad = 0;
    en0 = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || rd0 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL idle_empty bad_cycles=%0d exp=0", bad); end
    checks++; if (ws0 !== 8'd0) begin failures++; $display("FAIL idle_ws got=%0d exp=0", ws0); end
  endtask

  task automatic test_single;
    int base = rx_q0.size();
    int rdb  = rd_cnt[0];
    bit ok;
    push0(16'hA000);
    wait_rx(0, base + 1, 200, ok);
    tick(10);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=0 exp=1"); end
    else begin
      exp_ws++;
      checks++; if (rx_q0[base] !== 16'hA000) begin failures++; $display("FAIL single_data got=%h exp=a000", rx_q0[base]); end
      checks++; if (rd_cnt[0] - rdb != 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", rd_cnt[0] - rdb); end
      checks++; if (rx_t0[base] - rd_cyc[0] != 2) begin failures++; $display("FAIL single_latency got=%0d exp=2", rx_t0[base] - rd_cyc[0]); end
      checks++; if (busy_len[0] != int'(FRAME + 2)) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_len[0], FRAME + 2); end
      checks++; if (ws0 !== 8'(exp_ws)) begin failures++; $display("FAIL single_ws got=%0d exp=%0d", ws0, exp_ws); end
    end
  endtask

  task automatic test_back_to_back;
    int base = rx_q0.size();
    int rdb  = rd_cnt[0];
    int badp = 0;
    bit ok;
    for (int i = 0; i < 8; i++) push0(16'(16'hB000 + i));
    wait_rx(0, base + 8, 8 * PERIOD + 100, ok);
    tick(10);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=0 exp=1"); end
    else begin
      exp_ws += 8;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rx_q0[base+i] !== 16'(16'hB000 + i)) begin
          failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, rx_q0[base+i], 16'(16'hB000 + i));
        end
      end
      for (int i = 1; i < 8; i++) if (rx_t0[base+i] - rx_t0[base+i-1] != PERIOD) badp++;
      checks++; if (badp != 0) begin failures++; $display("FAIL b2b_period bad=%0d exp=0 (period %0d)", badp, PERIOD); end
      checks++; if (rd_cnt[0] - rdb != 8) begin failures++; $display("FAIL b2b_pops got=%0d exp=8", rd_cnt[0] - rdb); end
      checks++; if (bad_rd[0] != 0) begin failures++; $display("FAIL b2b_rd_empty got=%0d exp=0", bad_rd[0]); end
      checks++; if (ws0 !== 8'(exp_ws)) begin failures++; $display("FAIL b2b_ws got=%0d exp=%0d", ws0, exp_ws); end
    end
  endtask

  task automatic test_random;
    logic [15:0] exp_q[$];
    logic [15:0] w;
    int base = rx_q0.size();
    bit ok;
    for (int i = 0; i < 12; i++) begin
      w = 16'($urandom);
      exp_q.push_back(w);
      push0(w);
      tick(int'($urandom_range(30, 150)));
    end
    wait_rx(0, base + 12, 12 * PERIOD + 200, ok);
    tick(10);
    checks++; if (!ok) begin failures++; $display("FAIL rand_timeout got=0 exp=1"); end
    else begin
      exp_ws += 12;
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (rx_q0[base+i] !== exp_q[i]) begin
          failures++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, rx_q0[base+i], exp_q[i]);
        end
      end
      checks++; if (ws0 !== 8'(exp_ws)) begin failures++; $display("FAIL rand_ws got=%0d exp=%0d", ws0, exp_ws); end
    end
  endtask

  task automatic test_enable_drop;
    logic [15:0] rest[3];
    int base = rx_q0.size();
    int rdb  = rd_cnt[0];
    bit ok;
    push0(16'hC123);
    for (int i = 0; i < 3; i++) begin rest[i] = 16'($urandom); push0(rest[i]); end
    checks++; if (rd_cnt[0] - rdb != 1) begin failures++; $display("FAIL drop_first_pop got=%0d exp=1", rd_cnt[0] - rdb); end
    while (cyc < rd_cyc[0] + 2 + 7 * CPB) @(negedge clk);
    en0 = 1'b0;
    wait_rx(0, base + 1, 200, ok);
    tick(2 * PERIOD);
    checks++; if (!ok) begin failures++; $display("FAIL drop_timeout got=0 exp=1"); end
    else begin
      exp_ws++;
      checks++; if (rx_q0[base] !== 16'hC123) begin failures++; $display("FAIL drop_data got=%h exp=c123", rx_q0[base]); end
      checks++; if (rx_q0.size() != base + 1) begin failures++; $display("FAIL drop_extra_frames got=%0d exp=%0d", rx_q0.size(), base + 1); end
      checks++; if (rd_cnt[0] - rdb != 1) begin failures++; $display("FAIL drop_pops got=%0d exp=1", rd_cnt[0] - rdb); end
      checks++; if (tx0 !== 1'b1 || busy0 !== 1'b0) begin failures++; $display("FAIL drop_idle got=tx%b/busy%b exp=tx1/busy0", tx0, busy0); end
    end
    en0 = 1'b1;
    wait_rx(0, base + 4, 4 * PERIOD + 50, ok);
    tick(10);
    checks++; if (!ok) begin failures++; $display("FAIL drop_resume_timeout got=0 exp=1"); end
    else begin
      exp_ws += 3;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rx_q0[base+1+i] !== rest[i]) begin
          failures++; $display("FAIL drop_resume[%0d] got=%h exp=%h", i, rx_q0[base+1+i], rest[i]);
        end
      end
      checks++; if (ws0 !== 8'(exp_ws)) begin failures++; $display("FAIL drop_ws got=%0d exp=%0d", ws0, exp_ws); end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] w;
    int base = rx_q0.size();
    int rdb  = rd_cnt[0];
    bit ok;
    w = 16'($urandom);
    if (w == 16'hD456) w = 16'h1234;
    push0(16'hD456);
    push0(w);
    checks++; if (rd_cnt[0] - rdb != 1) begin failures++; $display("FAIL rmid_pop got=%0d exp=1", rd_cnt[0] - rdb); end
    while (cyc < rd_cyc[0] + 2 + 8 * CPB) @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++; if (tx0 !== 1'b1)   begin failures++; $display("FAIL rmid_tx got=%b exp=1", tx0); end
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy0); end
    checks++; if (ws0 !== 8'd0)   begin failures++; $display("FAIL rmid_ws got=%0d exp=0", ws0); end
    exp_ws = 0;
    tick(3);
    rstN = 1'b1;
    wait_rx(0, base + 1, 200, ok);
    tick(10);
    checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout got=0 exp=1"); end
    else begin
      exp_ws++;
      checks++; if (rx_q0[base] !== w) begin failures++; $display("FAIL rmid_next got=%h exp=%h", rx_q0[base], w); end
      checks++; if (ws0 !== 8'(exp_ws)) begin failures++; $display("FAIL rmid_ws_after got=%0d exp=%0d", ws0, exp_ws); end
    end
  endtask

  task automatic test_msb_wrap;
    logic [15:0] tail[4];
    int bad = 0;
    bit ok;
    for (int i = 0; i < 4; i++) tail[i] = 16'($urandom);
    en1 = 1'b1;
    fork
      begin
        for (int i = 0; i < 256; i++) push1(16'h8001);
        for (int i = 0; i < 4; i++) push1(tail[i]);
      end
    join_none
    wait_rx(1, 255, 255 * PERIOD + 300, ok);
    tick(4);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout255 got=0 exp=1"); end
    else begin
      checks++; if (ws1 !== 8'd255) begin failures++; $display("FAIL wrap_ws255 got=%0d exp=255", ws1); end
      for (int i = 0; i < 255; i++) if (rx_q1[i] !== 16'h8001) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL msb_8001 bad_frames=%0d exp=0", bad); end
    end
    wait_rx(1, 256, PERIOD + 50, ok);
    tick(4);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout256 got=0 exp=1"); end
    else begin
      checks++; if (ws1 !== 8'd0) begin failures++; $display("FAIL wrap_ws0 got=%0d exp=0", ws1); end
    end
    wait_rx(1, 260, 4 * PERIOD + 100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL msb_tail_timeout got=0 exp=1"); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_q1[256+i] !== tail[i]) begin
          failures++; $display("FAIL msb_order[%0d] got=%h exp=%h", i, rx_q1[256+i], tail[i]);
        end
      end
    end
    checks++; if (bad_rd[0] != 0 || bad_rd[1] != 0) begin failures++; $display("FAIL rd_while_empty got=%0d/%0d exp=0/0", bad_rd[0], bad_rd[1]); end
    checks++; if (rx_fe[0] != 0 || rx_fe[1] != 0) begin failures++; $display("FAIL framing got=%0d/%0d exp=0/0", rx_fe[0], rx_fe[1]); end
  endtask

  initial begin
    #1 rstN = 1'b0;
    test_reset();
    test_idle_empty();
    test_single();
    test_back_to_back();
    test_random();
    test_enable_drop();
    test_reset_mid();
    test_msb_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
